// File: rtl/riscv_dmem_model.sv
// riscv_dmem_model: parametrised data-memory responder for the Zilla RISC-V
// core data port. Byte-strobed writes, pipelined reads of READ_LAT cycles,
// out-of-range detection on both ports.
// Optional feature macro: RISCV_DMEM_BYPASS_EN
//   defined   -> a same-edge read and in-range write to one word return the
//                merged (post-write) word
//   undefined -> read-first: the read returns the pre-write word
module riscv_dmem_model #(
    parameter int D_WIDTH  = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int A_WIDTH  = 32
) (
    input  logic                 risc_clk,
    input  logic                 risc_rst,
    input  logic                 data_mem_write_en_i,
    input  logic [A_WIDTH-1:0]   data_mem_write_addr_i,
    input  logic [D_WIDTH-1:0]   data_mem_write_data_i,
    input  logic [D_WIDTH/8-1:0] data_mem_strobe_i,
    input  logic                 data_mem_read_en_i,
    input  logic [A_WIDTH-1:0]   data_mem_read_addr_i,
    output logic [D_WIDTH-1:0]   data_mem_read_data_o,
    output logic                 data_mem_read_valid_o,
    output logic                 data_mem_err_o
);

    localparam int NB  = D_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    // Reject configurations the address decode cannot represent.
    if (!(D_WIDTH == 32 || D_WIDTH == 64)) begin : g_bad_width
        $error("riscv_dmem_model: D_WIDTH must be 32 or 64");
    end
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("riscv_dmem_model: DEPTH must be a power of two >= 16");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("riscv_dmem_model: READ_LAT must be 1..4");
    end
    if (A_WIDTH < OFS + IW) begin : g_bad_awidth
        $error("riscv_dmem_model: A_WIDTH too small for DEPTH");
    end

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;
    logic               wr_oor;
    logic               rd_oor;
    logic               wr_fire;
    logic               rd_fire;
    logic [D_WIDTH-1:0] wr_word;
    logic [D_WIDTH-1:0] rd_word;

    logic [READ_LAT-1:0]              valid_q, valid_d;
    logic [READ_LAT-1:0]              err_q, err_d;
    logic [READ_LAT-1:0][D_WIDTH-1:0] data_q, data_d;
    logic                             wr_err_q, wr_err_d;

    // Decode both addresses, build the merged write word and the read word.
    always_comb begin
        wr_idx  = data_mem_write_addr_i[OFS +: IW];
        rd_idx  = data_mem_read_addr_i[OFS +: IW];
        wr_oor  = (data_mem_write_addr_i >> (OFS + IW)) != '0;
        rd_oor  = (data_mem_read_addr_i >> (OFS + IW)) != '0;
        wr_fire = data_mem_write_en_i && !risc_rst && !wr_oor;
        rd_fire = data_mem_read_en_i && !risc_rst;

        wr_word = mem_q[wr_idx];
        for (int b = 0; b < NB; b++) begin
            if (data_mem_strobe_i[b]) begin
                wr_word[8*b +: 8] = data_mem_write_data_i[8*b +: 8];
            end
        end

        rd_word = '0;
        if (!rd_oor) begin
            rd_word = mem_q[rd_idx];
`ifdef RISCV_DMEM_BYPASS_EN
            if (wr_fire && (wr_idx == rd_idx)) begin
                rd_word = wr_word;
            end
`endif
        end
    end

    // Array update; contents are deliberately left untouched by reset.
    always_ff @(posedge risc_clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    // Next state of the read pipeline and the write-error flag.
    always_comb begin
        valid_d    = '0;
        err_d      = '0;
        data_d     = '0;
        valid_d[0] = rd_fire;
        err_d[0]   = rd_fire && rd_oor;
        data_d[0]  = rd_fire ? rd_word : '0;
        for (int i = 1; i < READ_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        wr_err_d = data_mem_write_en_i && !risc_rst && wr_oor;
    end

    // Pipeline registers; reset drops every in-flight read.
    always_ff @(posedge risc_clk) begin
        if (risc_rst) begin
            valid_q  <= '0;
            err_q    <= '0;
            data_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            err_q    <= err_d;
            data_q   <= data_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign data_mem_read_data_o  = data_q[READ_LAT-1];
    assign data_mem_read_valid_o = valid_q[READ_LAT-1];
    assign data_mem_err_o        = err_q[READ_LAT-1] | wr_err_q;

endmodule

// File: tb/tb_riscv_dmem_model.sv
// Bench for riscv_dmem_model: drives one stimulus stream into a READ_LAT=1
// and a READ_LAT=3 instance; a reference memory predicts each read when it
// is issued and the predictions are compared when the outputs come due.
module tb_riscv_dmem_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        re;
    logic [31:0] raddr;

    logic [31:0] rdata1, rdata3;
    logic        rvalid1, rvalid3;
    logic        err1, err3;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    int          werr_q[$];
    logic [31:0] model [1024];

    always #5 clk = ~clk;

    riscv_dmem_model #(.D_WIDTH(32), .DEPTH(1024), .READ_LAT(1), .A_WIDTH(32)) dut1 (
        .risc_clk(clk), .risc_rst(rst),
        .data_mem_write_en_i(we), .data_mem_write_addr_i(waddr),
        .data_mem_write_data_i(wdata), .data_mem_strobe_i(strb),
        .data_mem_read_en_i(re), .data_mem_read_addr_i(raddr),
        .data_mem_read_data_o(rdata1), .data_mem_read_valid_o(rvalid1),
        .data_mem_err_o(err1)
    );

    riscv_dmem_model #(.D_WIDTH(32), .DEPTH(1024), .READ_LAT(3), .A_WIDTH(32)) dut3 (
        .risc_clk(clk), .risc_rst(rst),
        .data_mem_write_en_i(we), .data_mem_write_addr_i(waddr),
        .data_mem_write_data_i(wdata), .data_mem_strobe_i(strb),
        .data_mem_read_en_i(re), .data_mem_read_addr_i(raddr),
        .data_mem_read_data_o(rdata3), .data_mem_read_valid_o(rvalid3),
        .data_mem_err_o(err3)
    );

    // Reference model: predict reads at the issue edge, then apply writes.
    always @(posedge clk) begin
        logic [31:0] rv;
        logic        roor;
        logic        woor;
        edge_cnt++;
        if (rst) begin
            q1.delete();
            q3.delete();
            werr_q.delete();
        end else begin
            roor = raddr >= 32'h0000_1000;
            woor = waddr >= 32'h0000_1000;
            if (re) begin
                rv = roor ? 32'h0 : model[raddr[11:2]];
`ifdef RISCV_DMEM_BYPASS_EN
                if (!roor && we && !woor && (raddr[11:2] == waddr[11:2])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) rv[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
`endif
                q1.push_back('{edge_cnt, rv, roor});
                q3.push_back('{edge_cnt + 2, rv, roor});
            end
            if (we) begin
                if (woor) begin
                    werr_q.push_back(edge_cnt);
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) model[waddr[11:2]][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag,
                               input logic ev, input logic [31:0] ed, input logic ee,
                               input logic av, input logic [31:0] ad, input logic ae);
        checks++;
        assert (av === ev) else begin
            failures++;
            $error("[TB] FAIL %s valid edge=%0d got=%0b want=%0b", tag, edge_cnt, av, ev);
        end
        checks++;
        assert (ad === ed) else begin
            failures++;
            $error("[TB] FAIL %s data edge=%0d got=%h want=%h", tag, edge_cnt, ad, ed);
        end
        checks++;
        assert (ae === ee) else begin
            failures++;
            $error("[TB] FAIL %s err edge=%0d got=%0b want=%0b", tag, edge_cnt, ae, ee);
        end
    endtask

    // Scoreboard: every cycle pop what is due and compare all outputs.
    always @(negedge clk) begin
        logic        wr_e;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        if (edge_cnt > 0) begin
            wr_e = (werr_q.size() > 0) && (werr_q[0] == edge_cnt);
            if (wr_e) void'(werr_q.pop_front());

            ev = (q1.size() > 0) && (q1[0].due == edge_cnt);
            ed = 32'h0;
            ee = wr_e;
            if (ev) begin
                ed = q1[0].data;
                ee = q1[0].err | wr_e;
                void'(q1.pop_front());
            end
            checkOutput("lat1", ev, ed, ee, rvalid1, rdata1, err1);

            ev = (q3.size() > 0) && (q3[0].due == edge_cnt);
            ed = 32'h0;
            ee = wr_e;
            if (ev) begin
                ed = q3[0].data;
                ee = q3[0].err | wr_e;
                void'(q3.pop_front());
            end
            checkOutput("lat3", ev, ed, ee, rvalid3, rdata3, err3);
        end
    end

    task automatic applyStimulus(input logic w_en, input logic [31:0] w_a,
                                 input logic [31:0] w_d, input logic [3:0] w_s,
                                 input logic r_en, input logic [31:0] r_a,
                                 input logic rst_i);
        we    = w_en;
        waddr = w_a;
        wdata = w_d;
        strb  = w_s;
        re    = r_en;
        raddr = r_a;
        rst   = rst_i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        rst = 1'b1; we = 1'b0; re = 1'b0;
        waddr = '0; wdata = '0; strb = '0; raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Initialise the words the bench reads, plus the last in-range word.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i * 4), 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0FFC, 32'h7E57_0FFC, 4'hF, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0FFF, 1'b0);

        // Full write then read on the next edge.
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10, 1'b0);

        // Partial strobe merge.
        applyStimulus(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h22, 1'b0);

        // Same-edge read and write to one word, then read it back.
        applyStimulus(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h30, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30, 1'b0);
        idle(3);

        // Out-of-range read and write together, then alone; word 0 stays put.
        applyStimulus(1'b1, 32'h2000, 32'h5555_5555, 4'hF, 1'b1, 32'h1000, 1'b0);
        idle(3);
        applyStimulus(1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);

        // All-zero strobe writes nothing.
        applyStimulus(1'b1, 32'h10, 32'h0BAD_0BAD, 4'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10, 1'b0);
        idle(3);

        // Distinct words for the streaming test.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'(i * 4), 1'b0);
        idle(4);

        // Reads in flight are dropped by reset; a write during reset is ignored.
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'h0BAD_BEEF, 4'hF, 1'b1, 32'h8, 1'b1);
        idle(4);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4, 1'b0);
        idle(4);

        // Mixed traffic with random strobes and occasional out-of-range hits.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] wa;
            logic [31:0] ra;
            wa = ($urandom_range(0, 7) == 0) ? 32'h0000_1000 + 32'($urandom_range(0, 255))
                                              : 32'($urandom_range(0, 63));
            ra = ($urandom_range(0, 7) == 0) ? 32'h0001_0000 : 32'($urandom_range(0, 63));
            applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), ra, 1'b0);
        end
        idle(6);

        checks++;
        assert ((q1.size() + q3.size() + werr_q.size()) == 0) else begin
            failures++;
            $error("[TB] FAIL drain pending got=%0d want=0", q1.size() + q3.size() + werr_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_model.md
# riscv_dmem_model

Parametrised, synthesisable data-memory responder for the Zilla RISC-V core's data-memory port. Replaces the fixed 32-bit, zero-latency bench-driven data memory with a configurable-width, configurable-depth, configurable-read-latency memory. It supports byte strobes, out-of-range detection and optional same-cycle write-to-read forwarding. It sits between the core's `data_mem_*` port and the top-level bench, and runs on the core clock.

## Interface
- `D_WIDTH`, default 32: data width in bits; must be 32 or 64.
- `DEPTH`, default 1024: number of `D_WIDTH` words; must be a power of two, at least 16.
- `READ_LAT`, default 1: read latency in cycles, from 1 to 4.
- `A_WIDTH`, default 32: byte-address width.
- `risc_clk` input 1: core clock; all logic is on its rising edge.
- `risc_rst` input 1: reset; synchronous, active-high.
- `data_mem_write_en_i` input 1: write request.
- `data_mem_write_addr_i` input `A_WIDTH`: byte address of the write.
- `data_mem_write_data_i` input `D_WIDTH`: write data.
- `data_mem_strobe_i` input `D_WIDTH/8`: byte-enable mask for the write.
- `data_mem_read_en_i` input 1: read request.
- `data_mem_read_addr_i` input `A_WIDTH`: byte address of the read.
- `data_mem_read_data_o` output `D_WIDTH`: read data.
- `data_mem_read_valid_o` output 1: one-cycle pulse marking valid read data.
- `data_mem_err_o` output 1: out-of-range flag, aligned with the access it reports.

## Operation
- Word index is `addr[OFS+IW-1:OFS]`, where `OFS = log2(D_WIDTH/8)` and `IW = log2(DEPTH)`.
  - Low `OFS` bits are ignored; no misalign fault is raised.
  - An access is out of range when any of `addr[A_WIDTH-1:OFS+IW]` is non-zero.
- **Write:**
  - On an edge with `write_en=1` and the address in range, write byte *b* of the word when `strobe[b]=1`.
  - Bytes with `strobe[b]=0` keep their old value. A strobe of all zeros writes nothing.
  - An out-of-range write changes nothing and pulses `data_mem_err_o` on the next cycle.
- **Read:**
  - A read issued at edge N samples the array at that edge.
  - Data appears on `data_mem_read_data_o` with `data_mem_read_valid_o=1` during the cycle after edge N+READ_LAT-1, i.e. READ_LAT cycles later.
  - The read pipeline is READ_LAT stages of {valid, data, err}. Reads are fully pipelined: one may be issued every cycle, and there is no backpressure.
  - An out-of-range read returns 0 with `err=1` in the same cycle as its valid.
- **Write and error in the same cycle:** if both the write error and the read error are due in the same cycle, `data_mem_err_o` is their logical OR.
- **Outputs while idle:** when `data_mem_read_valid_o=0`, `data_mem_read_data_o` is held at 0.
- **Write after read issue:** a write at a later edge than the read's issue edge never alters that read's in-flight data.
- **Same-cycle read and write to the same word:** governed by `RISCV_DMEM_BYPASS_EN` (see Configuration).
- **Reset:**
  - Clears all pipeline valid and err bits, and forces all outputs to 0.
  - Array contents are not cleared.
  - Reads in flight when `risc_rst` is asserted are discarded: no valid is produced for them.
  - Requests presented while `risc_rst=1` are ignored.

## Timing
- **Reset values:** `data_mem_read_data_o=0`, `data_mem_read_valid_o=0`, `data_mem_err_o=0`.
- **Read latency:** exactly READ_LAT cycles from the request edge to valid data. The last pipeline stage is registered, with no combinational path from inputs to outputs.
- **Write:** takes effect at the request edge. A read issued at the next edge sees the new data.
- **Write error:** pulses for 1 cycle, 1 cycle after the write edge, independent of READ_LAT.
- **Back-to-back reads:** valid stays continuously high for the same number of cycles as the number of requests.

## Configuration
- `RISCV_DMEM_BYPASS_EN`:
  - **Defined:** a read and an in-range write to the same word at the same edge return the merged word. Bytes with their strobe set carry the new data; the other bytes carry the old data.
  - **Undefined:** the read returns the pre-write (old) word. This is read-first behaviour and the default.
- Out-of-range accesses are never forwarded, with or without the macro.

## Test plan
- READ_LAT=1: write `0xDEADBEEF` at byte address `0x10` with strobe `4'hF`; read `0x10` at the next edge. Required: valid 1 cycle later with data `0xDEADBEEF`, err=0.
- Partial strobe: word at `0x20` holds `0x11223344`; write `0xAABBCCDD` with strobe `4'b0101`. Required: a later read returns `0x11BB33DD`.
- Same-edge read and write at `0x30`: old word `0x0`, write `0xCAFEF00D`, strobe `4'hF`. Required: read returns `0xCAFEF00D` with `RISCV_DMEM_BYPASS_EN` defined, and `0x00000000` without it.
- DEPTH=1024, D_WIDTH=32: read `0x1000` (out of range) and write `0x2000`. Required: read valid with data 0 and err=1; write err pulse 1 cycle after the write edge; memory unchanged.
- READ_LAT=3: issue reads at 4 consecutive edges to `0x0`, `0x4`, `0x8`, `0xC`. Required: valid high for 4 consecutive cycles starting 3 cycles after the first request, with data in request order.
- READ_LAT=3: issue reads at edges N and N+1, then assert `risc_rst` at N+2 for 1 cycle. Required: no valid pulse appears; all outputs are 0 after the reset edge; the array retains the data written before reset.
